// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the display scan controller: code width, decoder bit map
// and FSM state encodings.
package disp_pkg;

  localparam int CODE_W = 5;

  localparam int C1_BIT = 4;
  localparam int C2_BIT = 3;
  localparam int C3_BIT = 2;
  localparam int C4_BIT = 1;
  localparam int C6_BIT = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Host write port into the scan controller's staging registers.
interface display_scan_ctrl_if
  import disp_pkg::*;
#(
  parameter int NDIG = 4
) ();

  logic                    wr_en;
  logic [$clog2(NDIG)-1:0] wr_idx;
  logic [CODE_W-1:0]       wr_data;

  modport master (output wr_en, output wr_idx, output wr_data);
  modport slave  (input  wr_en, input  wr_idx, input  wr_data);

endinterface

// File: rtl/display_scan_ctrl_timer.sv
// Loadable down-counter timing SHOW and GAP slots; done pulses once per load
// when the count has run down to zero.
module scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;
  logic         armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign done = armed && (count == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexes NDIG double-buffered 5-bit codes onto one segment decoder with
// active-low digit selects and an optional blanking gap between digits.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int DWELL     = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  display_scan_ctrl_if.slave wr,
  output logic [CODE_W-1:0] code_out,
  output logic [NDIG-1:0]   dig_sel_n,
  output logic              blank,
  output logic              frame_tick
);

  localparam int IW   = $clog2(NDIG);
  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] DWELL_LD = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LD = TW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  logic [1:0]        state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [CODE_W-1:0] staging     [NDIG];
  logic [CODE_W-1:0] shadow      [NDIG];
  logic [CODE_W-1:0] staging_nxt [NDIG];
  logic [CODE_W-1:0] shadow_nxt  [NDIG];
  logic              load, done, wrap, last_dig, copy;
  logic [TW-1:0]     load_val;

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  assign last_dig = (int'(idx) == NDIG - 1);
  assign copy     = (state == ST_IDLE) || wrap;

  // Out-of-range indices match no entry, so such writes fall away naturally;
  // writes landing on a copy edge are forwarded straight into the shadow.
  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      staging_nxt[i] = staging[i];
      if (wr.wr_en && (int'(wr.wr_idx) == i)) staging_nxt[i] = wr.wr_data;
      shadow_nxt[i] = copy ? staging_nxt[i] : shadow[i];
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    load_val  = DWELL_LD;
    wrap      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_SHOW;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      ST_SHOW: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else if (done) begin
          load = 1'b1;
          if (BLANK_CYC > 0) begin
            state_nxt = ST_GAP;
            load_val  = BLANK_LD;
          end else begin
            wrap    = last_dig;
            idx_nxt = last_dig ? '0 : idx + IW'(1);
          end
        end
      end
      ST_GAP: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else if (done) begin
          state_nxt = ST_SHOW;
          load      = 1'b1;
          wrap      = last_dig;
          idx_nxt   = last_dig ? '0 : idx + IW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      for (int i = 0; i < NDIG; i++) begin
        staging[i] <= '0;
        shadow[i]  <= '0;
      end
      code_out   <= '0;
      dig_sel_n  <= '1;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      staging    <= staging_nxt;
      shadow     <= shadow_nxt;
      frame_tick <= wrap;
      blank      <= (state_nxt != ST_SHOW);
      if (state_nxt == ST_SHOW) begin
        dig_sel_n <= ~(NDIG'(1) << idx_nxt);
        code_out  <= shadow_nxt[idx_nxt];
      end else begin
        dig_sel_n <= '1;
      end
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes NDIG stored 5-bit display codes onto one shared 7-segment decoder (inputs c1,c2,c3,c4,c6 → segments A–G).
- Drives one active-low digit-select line per digit, with a blanking gap between digits to suppress ghosting.
- Double-buffers written codes so a frame never shows mixed old/new data.
- Sits between the host/control logic and the combinational segment decoder.

Parameters:
NDIG, 4, number of multiplexed digits (2..8)
DWELL, 50000, clock cycles each digit is lit (≥1)
BLANK_CYC, 16, all-off clock cycles between digits (0 = no gap)
CODE_W, 5, code width; fixed at 5 to match the decoder inputs

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  1 = scanning; 0 = all digits off
wr_en  in  1  write strobe for one staging register
wr_idx  in  $clog2(NDIG)  digit index for the write
wr_data  in  CODE_W  code for the write; [4]=c1,[3]=c2,[2]=c3,[1]=c4,[0]=c6
code_out  out  CODE_W  code to the decoder, same bit order as wr_data
dig_sel_n  out  NDIG  active-low digit enables; at most one bit is 0
blank  out  1  1 when no digit is lit
frame_tick  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Reset (async assert, sync release):
  - staging and shadow registers = 0, idx = 0, state = IDLE
  - code_out = 0, dig_sel_n = all 1, blank = 1, frame_tick = 0
- All outputs are registered and change on the same edge as the state.
- States: IDLE, SHOW, GAP.
- IDLE:
  - dig_sel_n = all 1, blank = 1.
  - Each cycle, shadow copies staging, so writes become visible directly.
  - enable = 1 sampled at edge k → SHOW at edge k+1 with idx = 0, dig_sel_n[0] = 0, code_out = shadow[0], blank = 0.
- SHOW:
  - Lasts exactly DWELL cycles: dig_sel_n[idx] = 0, code_out = shadow[idx].
  - Then GAP if BLANK_CYC > 0, otherwise straight to the next digit's SHOW.
- GAP:
  - Lasts BLANK_CYC cycles: dig_sel_n = all 1, blank = 1, code_out holds its last value.
  - Then SHOW with idx+1.
- Wrap:
  - When the slot of idx = NDIG-1 ends (end of its GAP, or of its SHOW if BLANK_CYC = 0), idx → 0.
  - frame_tick = 1 for exactly that one cycle.
  - Shadow copies staging on the same edge.
- Write rules:
  - wr_en writes staging[wr_idx] in every state.
  - wr_idx ≥ NDIG: the write is ignored.
  - Write coinciding with the frame-boundary copy: the new wr_data goes into shadow on that edge (write-through).
- enable deassert: enable = 0 sampled in SHOW or GAP → IDLE on the next edge. Outputs go dark the same edge, idx = 0, frame_tick stays 0.
- enable reassert: always restarts at digit 0 with a full DWELL.
- Reset mid-scan: outputs return to reset values immediately; staging contents are lost.
- Frame period = NDIG × (DWELL + BLANK_CYC) cycles.

Decomposition:
- Package disp_pkg:
  - state enum (IDLE, SHOW, GAP)
  - CODE_W = 5
  - bit-position constants mapping code bits to decoder inputs c1, c2, c3, c4, c6
- Sub-module scan_timer: loadable down-counter.
  - Inputs: clk, rst_n, load, load_val.
  - Output: done, a single-cycle pulse when the count reaches 0.
  - Shared by the SHOW and GAP durations; the counter width covers max(DWELL, BLANK_CYC).

Test Plan (NDIG=4, DWELL=4, BLANK_CYC=2 unless stated):
- Reset with enable = 1 → all outputs at reset values; 1 cycle after rst_n release, dig_sel_n = 4'b1110, code_out = shadow[0].
- Write codes 5'h03, 5'h11, 5'h1F, 5'h00 to idx 0..3 while IDLE, then enable:
  - sequence: 1110/03 for 4 cycles, all-off for 2, 1101/11, 1011/1F, 0111/00
  - frame_tick on cycle 24; period 24 cycles.
- Mid-frame write of 5'h0A to idx 0 while idx 2 is lit → digit 0 keeps its old code for the rest of the frame; shows 0A from the next frame.
- Write to idx 1 on the exact frame_tick cycle → the new value is displayed in the very next frame.
- Drop enable during GAP of digit 1 → next edge dig_sel_n = 1111, blank = 1; on reenable, scan restarts at digit 0 with a full 4-cycle dwell.
- BLANK_CYC = 0 build → digits switch back-to-back, blank never 1 while enabled, frame period 16 cycles.
